// File: rtl/key_search_ctrl.sv
// key_search_ctrl
//   Candidate-key search controller for a TEA brute-force pipeline. It issues
//   candidate indices 0 .. 2^IDX_W-1 into an external TEA pipeline of depth
//   LATENCY. A matching delay line carries {valid, index} so every pipeline
//   output word can be tied back to the candidate that produced it. A
//   decrypted block starting with "%PDF-1." followed by an ASCII digit is a hit.
//
//   Ports
//     clk          single clock, rising edge
//     rst          synchronous, active-high reset (beats everything else)
//     ena          issue enable; low inserts a bubble instead of a candidate
//     start        one-cycle pulse, begins a search from IDLE, DONE or FOUND
//     abort        one-cycle pulse, cancels the search (beats start and hit)
//     pipe_data    64-bit TEA pipeline output word
//     cand_valid   a candidate is issued this cycle
//     cand_index   index of the candidate issued this cycle
//     busy         search running or draining
//     done         search finished, with or without a hit
//     found        plaintext match detected
//     found_index  index of the candidate that matched
//     hit_count    (only with KEY_SEARCH_CTRL_MULTI_HIT_EN) saturating count
//                  of hits in the current search
//
//   Optional feature macro: KEY_SEARCH_CTRL_MULTI_HIT_EN
//     Defined   : every hit pulses found for one cycle, updates found_index and
//                 hit_count, and the search runs on to the end of the space.
//     Undefined : the first hit ends the search in FOUND.
module key_search_ctrl #(
  parameter int LATENCY = 32,
  parameter int IDX_W   = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [63:0]      pipe_data,
  output logic             cand_valid,
  output logic [IDX_W-1:0] cand_index,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] found_index
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
  ,
  output logic [7:0]       hit_count
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FOUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // "%PDF-1." in ASCII; the following byte must be a decimal digit
  localparam logic [55:0]      PDF_PREFIX = 56'h255044462D312E;
  localparam logic [IDX_W-1:0] LAST_INDEX = '1;

  logic [2:0]       state_reg;
  logic [IDX_W-1:0] counter_reg;
  logic             done_reg;
  logic             found_reg;
  logic [IDX_W-1:0] found_index_reg;
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
  logic [7:0]       hit_count_reg;
`endif

  // Delay line: element 0 is the newest entry, LATENCY-1 lines up with pipe_data
  logic             dl_valid_reg [LATENCY];
  logic [IDX_W-1:0] dl_index_reg [LATENCY];

  logic start_accept;
  logic flush;
  logic pending;
  logic hit;
  logic last_issue;

  assign cand_valid  = (state_reg == S_RUN) && ena;
  assign cand_index  = counter_reg;
  assign busy        = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done        = done_reg;
  assign found       = found_reg;
  assign found_index = found_index_reg;
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
  assign hit_count   = hit_count_reg;
`endif

  assign start_accept = start && !abort &&
                        ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                         (state_reg == S_FOUND));

  // Starting a new search also discards whatever a finished search left in
  // flight, so stale candidates can never be reported against the new run.
  assign flush = rst || abort || start_accept;

  assign hit = dl_valid_reg[LATENCY-1] &&
               (pipe_data[63:8] == PDF_PREFIX) &&
               (pipe_data[7:0] >= 8'h30) && (pipe_data[7:0] <= 8'h39);

  assign last_issue = cand_valid && (counter_reg == LAST_INDEX);

  // Entries still travelling down the line. The output stage is excluded: it
  // is judged for a hit this very cycle, so draining can finish alongside it.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      pending = pending | dl_valid_reg[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (flush) begin
            dl_valid_reg[gi] <= 1'b0;
          end else begin
            dl_valid_reg[gi] <= cand_valid;
          end
          dl_index_reg[gi] <= cand_index;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (flush) begin
            dl_valid_reg[gi] <= 1'b0;
          end else begin
            dl_valid_reg[gi] <= dl_valid_reg[gi-1];
          end
          dl_index_reg[gi] <= dl_index_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      counter_reg     <= '0;
      done_reg        <= 1'b0;
      found_reg       <= 1'b0;
      found_index_reg <= '0;
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
      hit_count_reg   <= 8'd0;
`endif
    end else if (abort) begin
      state_reg <= S_IDLE;
      done_reg  <= 1'b0;
      found_reg <= 1'b0;
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
      hit_count_reg <= 8'd0;
`endif
    end else begin
      case (state_reg)
        S_RUN, S_DRAIN: begin
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
          // Report every hit as a pulse and keep going
          found_reg <= hit;
          if (hit) begin
            found_index_reg <= dl_index_reg[LATENCY-1];
            if (hit_count_reg != 8'hFF) begin
              hit_count_reg <= hit_count_reg + 8'd1;
            end
          end
          if (state_reg == S_RUN) begin
            if (last_issue) begin
              state_reg <= S_DRAIN;
            end else if (cand_valid) begin
              counter_reg <= counter_reg + IDX_W'(1);
            end
          end else if (!pending) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
`else
          // First hit wins, even over the last issue or drain completion
          if (hit) begin
            state_reg       <= S_FOUND;
            found_reg       <= 1'b1;
            done_reg        <= 1'b1;
            found_index_reg <= dl_index_reg[LATENCY-1];
          end else if (state_reg == S_RUN) begin
            if (last_issue) begin
              state_reg <= S_DRAIN;
            end else if (cand_valid) begin
              counter_reg <= counter_reg + IDX_W'(1);
            end
          end else if (!pending) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
`endif
        end
        default: begin
          // IDLE, DONE and FOUND hold everything until a start
          if (start_accept) begin
            state_reg   <= S_RUN;
            counter_reg <= '0;
            done_reg    <= 1'b0;
            found_reg   <= 1'b0;
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
            hit_count_reg <= 8'd0;
`endif
          end
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
          else begin
            found_reg <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl with IDX_W=4, LATENCY=32. Each search is planned
// up front as a timeline of expected outputs (issue times from the ena
// pattern, hit times = issue time + LATENCY, result one cycle later), and
// pipe_data is produced from that plan, standing in for the TEA pipeline.
module tb_key_search_ctrl;

  localparam int L  = 32;
  localparam int IW = 4;
  localparam int NC = 16;   // candidates in the space
  localparam int W  = 72;   // observed cycles per search
  localparam int NO = 1000; // "never"
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif
  localparam logic [55:0] PDF = 56'h255044462D312E;

  logic          clk = 1'b0;
  logic          rst, ena, start, abort;
  logic [63:0]   pipe_data;
  logic          cand_valid, busy, done, found;
  logic [IW-1:0] cand_index, found_index;
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
  logic [7:0]    hit_count;
`endif

  always #5 clk = ~clk;

  key_search_ctrl #(.LATENCY(L), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
    .pipe_data(pipe_data), .cand_valid(cand_valid), .cand_index(cand_index),
    .busy(busy), .done(done), .found(found), .found_index(found_index)
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
    , .hit_count(hit_count)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cur_test = 0;

  // test description
  int t_ena_mode, t_abort_at, t_start_at, match_a, match_b;

  // plan / expectations, indexed by cycle after the start-sampling edge
  bit iss[W];
  int iidx[W];
  bit e_busy[W], e_done[W], e_found[W];
  int e_fidx[W], e_hc[W];

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL test%0d %s cycle %0d: got %0h want %0h", cur_test, name, k, act, exp);
    end
  endtask

  function automatic bit is_match(input int idx);
    return (idx == match_a) || (idx == match_b);
  endfunction

  function automatic bit ena_at(input int k);
    return (t_ena_mode == 0) ? 1'b1 : (k % 2 == 0);
  endfunction

  // What the TEA pipeline emits in cycle k
  function automatic logic [63:0] pipe_word(input int k);
    int idx;
    if (k >= L && iss[k-L]) begin
      idx = iidx[k-L];
      if (is_match(idx)) return {PDF, (idx % 2 == 1) ? 8'h39 : 8'h30};
      case (idx % 4)
        0: return {PDF, 8'h2F};
        1: return {PDF, 8'h3A};
        2: return {PDF ^ 56'h1, 8'h35};
        default: return {$urandom(), $urandom()};
      endcase
    end
    // A matching word with nothing valid behind it must be ignored
    return {PDF, 8'h37};
  endfunction

  task automatic build_model();
    int idx, last, h1, fin, hc, fi;
    bit hit_at[W];
    int hit_idx[W];
    idx = 0; last = -1; h1 = -1;
    for (int k = 0; k < W; k++) begin
      iss[k] = 0; iidx[k] = 0; hit_at[k] = 0; hit_idx[k] = 0;
    end
    for (int k = 0; k < W; k++) begin
      if (last < 0 && k <= t_abort_at && ena_at(k)) begin
        iss[k] = 1; iidx[k] = idx;
        if (idx == NC - 1) last = k; else idx++;
      end
    end
    for (int k = 0; k + L < W; k++) begin
      if (iss[k] && is_match(iidx[k]) && k + L < t_abort_at) begin
        hit_at[k+L] = 1; hit_idx[k+L] = iidx[k];
        if (h1 < 0) h1 = k + L;
      end
    end
    if (!MULTI && h1 >= 0) begin
      for (int k = h1 + 1; k < W; k++) iss[k] = 0;
      if (last > h1) last = -1;
      fin = h1 + 1;
    end else begin
      fin = (last >= 0) ? last + L + 1 : NO;
    end
    hc = 0; fi = 0;
    for (int k = 0; k < W; k++) begin
      if (k > 0 && hit_at[k-1]) begin
        hc++; fi = hit_idx[k-1];
      end
      e_busy[k] = (k < fin);
      e_done[k] = (k >= fin);
      if (MULTI) begin
        e_found[k] = (k > 0) && hit_at[k-1];
        e_hc[k] = hc;
        e_fidx[k] = fi;
      end else begin
        e_found[k] = (h1 >= 0) && (k >= fin);
        e_hc[k] = 0;
        e_fidx[k] = (h1 >= 0) ? hit_idx[h1] : 0;
      end
      if (k > t_abort_at) begin
        e_busy[k] = 0; e_done[k] = 0; e_found[k] = 0; e_hc[k] = 0; iss[k] = 0;
      end
    end
  endtask

  function automatic int first_found();
    for (int k = 0; k < W; k++) if (e_found[k]) return k;
    return -1;
  endfunction

  function automatic int first_done();
    for (int k = 0; k < W; k++) if (e_done[k]) return k;
    return -1;
  endfunction

  task automatic run_search();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; ena = 1'b0; pipe_data = 64'd0;
    @(posedge clk); #1;
    for (int k = 0; k < W; k++) begin
      ena = ena_at(k);
      abort = (k == t_abort_at);
      start = (k == t_start_at);
      pipe_data = pipe_word(k);
      @(negedge clk);
      chk("cand_valid", k, 64'(cand_valid), 64'(iss[k]));
      if (iss[k]) chk("cand_index", k, 64'(cand_index), 64'(iidx[k]));
      chk("busy", k, 64'(busy), 64'(e_busy[k]));
      chk("done", k, 64'(done), 64'(e_done[k]));
      chk("found", k, 64'(found), 64'(e_found[k]));
      if (e_found[k]) chk("found_index", k, 64'(found_index), 64'(e_fidx[k]));
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
      chk("hit_count", k, 64'(hit_count), 64'(e_hc[k]));
`endif
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; ena = 1'b0;
    $display("test %0d: ena_mode=%0d matches=%0d,%0d abort_at=%0d checked %0d cycles",
             cur_test, t_ena_mode, match_a, match_b, t_abort_at, W);
  endtask

  task automatic setup(input int id, input int em, input int ab, input int st,
                       input int ma, input int mb);
    cur_test = id; t_ena_mode = em; t_abort_at = ab; t_start_at = st;
    match_a = ma; match_b = mb;
    build_model();
  endtask

  initial begin
    // reset with start held high: reset must win
    rst = 1'b1; ena = 1'b1; start = 1'b1; abort = 1'b0; pipe_data = {PDF, 8'h31};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0; ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_cand_valid", k, 64'(cand_valid), 64'd0);
      chk("rst_cand_index", k, 64'(cand_index), 64'd0);
      chk("rst_busy", k, 64'(busy), 64'd0);
      chk("rst_done", k, 64'(done), 64'd0);
      chk("rst_found", k, 64'(found), 64'd0);
      chk("rst_found_index", k, 64'(found_index), 64'd0);
`ifdef KEY_SEARCH_CTRL_MULTI_HIT_EN
      chk("rst_hit_count", k, 64'(hit_count), 64'd0);
`endif
    end
    $display("test 0: reset and 5 idle cycles checked");

    // index 5 matches: issued cycle 5, seen cycle 37, found from cycle 38
    setup(1, 0, NO, NO, 5, -1);
    chk("pin_found_cycle", 0, 64'(first_found()), 64'd38);
    run_search();

    // no match, restarted straight from FOUND: last issue cycle 15, done at 48
    setup(2, 0, NO, NO, -1, -1);
    chk("pin_done_cycle", 0, 64'(first_done()), 64'd48);
    chk("pin_no_found", 0, 64'(first_found()), 64'hFFFF_FFFF_FFFF_FFFF);
    run_search();

    // ena 1,0,1,0...: index 1 issued at cycle 2; a start while busy is ignored
    setup(3, 1, NO, 12, 1, -1);
    chk("pin_bubble_issue", 0, 64'(iidx[2]), 64'd1);
    chk("pin_bubble_gap", 0, 64'(iss[1]), 64'd0);
    chk("pin_bubble_found", 0, 64'(first_found()), 64'd35);
    run_search();

    // abort at cycle 10, match for index 3 arrives later and must be ignored
    setup(4, 0, 10, NO, 3, -1);
    run_search();

    // restart from IDLE after abort; matches for indices 2 and 9
    setup(5, 0, NO, NO, 2, 9);
    chk("pin_two_hits", 0, 64'(first_found()), 64'd35);
    run_search();

    // match on the very last index: hit coincides with drain completion
    setup(6, 0, NO, NO, 15, -1);
    chk("pin_last_found", 0, 64'(first_found()), 64'd48);
    run_search();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
